surf_trig_rx: RTL and testbench
===============================

// Module: surf_trig_rx
// PURPOSE
//  Receive end of the SURF trigger link: deframes the 16-bit halfword trigger stream (address word first,
//  metadata word second), checks framing, and emits one 20-bit decoded trigger {meta,addr} per frame on an
//  AXI4-Stream master through a 2-entry output buffer. Sits on the TURF side, after link deserialization.
// PARAMETERS
//  TIMEOUT    16   max ifclk cycles allowed between address word and metadata word (2..255)
//  IFCLKTYPE  "NONE"  clock-domain tag for CDC constraints, passed to attributes only
// PORTS
//  ifclk          in   1   interface clock
//  ifclk_rstn     in   1   asynchronous active-low reset
//  clear_i        in   1   synchronous flush: FSM to S_ADDR, buffer emptied, counters zeroed
//  s_trig_tdata   in   16  incoming halfword
//  s_trig_tvalid  in   1   halfword valid
//  s_trig_tready  out  1   halfword accepted when tvalid&&tready
//  m_trig_tdata   out  20  {meta[7:0], addr[11:0]}
//  m_trig_tvalid  out  1   decoded trigger valid
//  m_trig_tready  in   1   downstream accept
//  frame_err_o    out  1   one-cycle pulse per framing error
//  trig_count_o   out  16  saturating accepted-trigger count (TRIG_RX_STATS_EN only)
//  err_count_o    out  16  saturating framing-error count (TRIG_RX_STATS_EN only)
// BEHAVIOUR
//  - Reset (async, ifclk_rstn=0): FSM=S_ADDR, buffer empty, m_trig_tvalid=0, m_trig_tdata=0,
//    frame_err_o=0, counters=0, timeout counter=0. s_trig_tready=1 the first cycle after reset release.
//  - Address word valid iff tdata[15:14]==2'b10 && tdata[1:0]==2'b00; addr=tdata[13:2].
//  - Meta word valid iff tdata[15:8]==8'h00; meta=tdata[7:0].
//  - S_ADDR: s_trig_tready=1. Valid address word -> latch addr, go S_META, timeout cnt=0.
//    Any other word -> drop, frame_err_o pulse, stay S_ADDR.
//  - S_META: s_trig_tready = !buffer_full. On handshake:
//      meta word    -> push {meta,addr} to buffer, go S_ADDR.
//      address word -> frame_err_o pulse, discard old addr, latch new addr, stay S_META, timeout cnt=0.
//      other        -> frame_err_o pulse, discard frame, go S_ADDR.
//    No handshake -> timeout cnt+1; reaching TIMEOUT -> frame_err_o pulse, go S_ADDR. Timeout counts
//    stall cycles even when s_trig_tready=0 (backpressure longer than TIMEOUT also aborts the frame).
//  - frame_err_o is registered: asserted the cycle after the offending event; at most one per cycle.
//  - Latency: meta-word handshake at cycle N -> m_trig_tvalid=1 with that data at N+1 if buffer was empty.
//  - Buffer: 2-entry FIFO, first-word-fall-through, in-order. Push and pop in the same cycle when full is
//    legal (count unchanged). m_trig_tdata holds stable while tvalid&&!tready (AXI4-S rule).
//  - No trigger is ever dropped for lack of space: backpressure only via s_trig_tready in S_META.
//  - clear_i has priority over any handshake in the same cycle; the handshake word is discarded and no
//    error is flagged. s_trig_tready=0 while clear_i=1.
// CONFIGURATION
//  TRIG_RX_STATS_EN defined: trig_count_o +1 per buffer push, err_count_o +1 per frame_err_o pulse,
//    both saturate at 16'hFFFF, cleared by reset or clear_i.
//  TRIG_RX_STATS_EN undefined: no counter logic; trig_count_o and err_count_o are tied 16'h0000.
// TESTING
//  1. Words 0x848C,0x005A, m_tready=1 -> one cycle later m_tdata=20'h5A123, m_tvalid=1 one cycle; no err.
//  2. Word 0x848D in S_ADDR -> frame_err_o one pulse, no output; then 0x848C,0x0001 -> m_tdata=20'h01123.
//  3. 0x848C, then 0x8000 (addr 0x000), then 0x00FF -> one err pulse, single output 20'hFF000.
//  4. 0x848C, then idle TIMEOUT=16 cycles -> err pulse at cycle 17; following 0x005A dropped + err pulse.
//  5. m_tready=0, send 3 frames (addrs 1,2,3) -> 2 buffered, s_tready=0 after 3rd addr word; raise
//     m_tready within TIMEOUT -> outputs addrs 1,2,3 in order, no err. (STATS_EN: trig_count_o=3.)
//  6. Assert ifclk_rstn=0 mid-frame (after addr word, buffer holding 1) -> m_tvalid=0 immediately;
//     after release, lone 0x005A -> frame_err_o pulse, no output.

Source files
------------

// File: rtl/surf_trig_rx.sv
// SURF trigger link receiver: deframes address/meta halfwords into 20-bit triggers.
// Optional TRIG_RX_STATS_EN adds saturating trigger and framing-error counters.
module surf_trig_rx #(
    parameter int    TIMEOUT   = 16,
    parameter string IFCLKTYPE = "NONE"
) (
    input  logic        ifclk,
    input  logic        ifclk_rstn,
    input  logic        clear_i,
    input  logic [15:0] s_trig_tdata,
    input  logic        s_trig_tvalid,
    output logic        s_trig_tready,
    output logic [19:0] m_trig_tdata,
    output logic        m_trig_tvalid,
    input  logic        m_trig_tready,
    output logic        frame_err_o,
    output logic [15:0] trig_count_o,
    output logic [15:0] err_count_o
);

    typedef enum logic {
        S_ADDR,
        S_META
    } state_t;

    localparam bit unused_clktype = (IFCLKTYPE == "");

    (* CUSTOM_CC_DST = IFCLKTYPE *)
    state_t      state;
    logic [11:0] addr_q;
    logic [7:0]  tmo_cnt;
    logic        err_q;

    logic [19:0] mem [2];
    logic        wptr;
    logic        rptr;
    logic [1:0]  count;

    logic        is_addr;
    logic        is_meta;
    logic        full;
    logic        hs;
    logic        push;
    logic        pop;

    assign is_addr = (s_trig_tdata[15:14] == 2'b10) &&
                     (s_trig_tdata[1:0] == 2'b00);
    assign is_meta = (s_trig_tdata[15:8] == 8'h00);
    assign full    = (count == 2'd2);

    assign s_trig_tready = !clear_i &&
                           ((state == S_ADDR) || !full);
    assign hs   = s_trig_tvalid && s_trig_tready;
    assign push = hs && (state == S_META) && is_meta;
    assign pop  = m_trig_tvalid && m_trig_tready;

    // Frame state machine; frame_err_o is the registered err_q.
    always_ff @(posedge ifclk or negedge ifclk_rstn) begin
        if (!ifclk_rstn) begin
            state   <= S_ADDR;
            addr_q  <= '0;
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else if (clear_i) begin
            state   <= S_ADDR;
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state)
                S_ADDR: begin
                    if (hs) begin
                        if (is_addr) begin
                            addr_q  <= s_trig_tdata[13:2];
                            tmo_cnt <= '0;
                            state   <= S_META;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_META: begin
                    if (hs) begin
                        unique case (1'b1)
                            is_meta: begin
                                state <= S_ADDR;
                            end
                            is_addr: begin
                                err_q   <= 1'b1;
                                addr_q  <= s_trig_tdata[13:2];
                                tmo_cnt <= '0;
                            end
                            default: begin
                                err_q <= 1'b1;
                                state <= S_ADDR;
                            end
                        endcase
                    end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        state <= S_ADDR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: state <= S_ADDR;
            endcase
        end
    end

    assign frame_err_o = err_q;

    // Two-entry first-word-fall-through output buffer.
    always_ff @(posedge ifclk or negedge ifclk_rstn) begin
        if (!ifclk_rstn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            count  <= '0;
        end else if (clear_i) begin
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= {s_trig_tdata[7:0], addr_q};
                wptr      <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign m_trig_tvalid = (count != 2'd0);
    assign m_trig_tdata  = mem[rptr];

`ifdef TRIG_RX_STATS_EN
    logic [15:0] trig_cnt;
    logic [15:0] err_cnt;

    always_ff @(posedge ifclk or negedge ifclk_rstn) begin
        if (!ifclk_rstn) begin
            trig_cnt <= '0;
            err_cnt  <= '0;
        end else if (clear_i) begin
            trig_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (push && (trig_cnt != 16'hFFFF)) begin
                trig_cnt <= trig_cnt + 16'd1;
            end
            if (err_q && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

    assign trig_count_o = trig_cnt;
    assign err_count_o  = err_cnt;
`else
    assign trig_count_o = 16'h0000;
    assign err_count_o  = 16'h0000;
`endif

endmodule

// File: tb/tb_surf_trig_rx.sv
// Scoreboard bench for surf_trig_rx: directed frames, error pulses, backpressure, clear, reset.
module tb_surf_trig_rx;

    logic        ifclk = 1'b0;
    logic        ifclk_rstn = 1'b0;
    logic        clear_i = 1'b0;
    logic [15:0] s_trig_tdata = '0;
    logic        s_trig_tvalid = 1'b0;
    logic        s_trig_tready;
    logic [19:0] m_trig_tdata;
    logic        m_trig_tvalid;
    logic        m_trig_tready = 1'b1;
    logic        frame_err_o;
    logic [15:0] trig_count_o;
    logic [15:0] err_count_o;

    surf_trig_rx #(
        .TIMEOUT   (16),
        .IFCLKTYPE ("NONE")
    ) dut (
        .ifclk         (ifclk),
        .ifclk_rstn    (ifclk_rstn),
        .clear_i       (clear_i),
        .s_trig_tdata  (s_trig_tdata),
        .s_trig_tvalid (s_trig_tvalid),
        .s_trig_tready (s_trig_tready),
        .m_trig_tdata  (m_trig_tdata),
        .m_trig_tvalid (m_trig_tvalid),
        .m_trig_tready (m_trig_tready),
        .frame_err_o   (frame_err_o),
        .trig_count_o  (trig_count_o),
        .err_count_o   (err_count_o)
    );

    always #5 ifclk = ~ifclk;

    int          checks = 0;
    int          errors = 0;
    logic [19:0] exp_q[$];
    int          err_seen = 0;
    int          err_exp = 0;
    int          stat_trig = 0;
    int          stat_err = 0;
    logic        prev_stall = 1'b0;
    logic [19:0] prev_data = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: counts error pulses, checks hold rule, pops scoreboard.
    always @(negedge ifclk) begin
        if (frame_err_o === 1'b1) err_seen++;
        if (prev_stall && ifclk_rstn)
            chk("hold", {12'h0, m_trig_tdata}, {12'h0, prev_data});
        prev_stall = m_trig_tvalid && !m_trig_tready && ifclk_rstn;
        prev_data  = m_trig_tdata;
        if (m_trig_tvalid && m_trig_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out got %h want none",
                         m_trig_tdata);
            end else begin
                chk("out", {12'h0, m_trig_tdata},
                    {12'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic send(input logic [15:0] w);
        logic r;
        r = 1'b0;
        s_trig_tdata  = w;
        s_trig_tvalid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge ifclk);
            r = s_trig_tready;
            @(posedge ifclk);
            #1;
            if (r) break;
        end
        if (!r) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got no_ready want ready word %h", w);
        end
        s_trig_tvalid = 1'b0;
    endtask

    task automatic settle(input string name);
        repeat (3) @(posedge ifclk);
        #1;
        chk(name, err_seen, err_exp);
    endtask

    task automatic chk_stats(input string name);
`ifdef TRIG_RX_STATS_EN
        chk({name, "_trig"}, {16'h0, trig_count_o}, stat_trig);
        chk({name, "_err"}, {16'h0, err_count_o}, stat_err);
`else
        chk({name, "_trig"}, {16'h0, trig_count_o}, 0);
        chk({name, "_err"}, {16'h0, err_count_o}, 0);
`endif
    endtask

    initial begin
        #1;
        chk("rst_tvalid", {31'h0, m_trig_tvalid}, 0);
        chk("rst_tdata", {12'h0, m_trig_tdata}, 0);
        chk("rst_err", {31'h0, frame_err_o}, 0);
        chk_stats("rst");
        repeat (3) @(posedge ifclk);
        #1 ifclk_rstn = 1'b1;
        @(posedge ifclk);
        #1 chk("rst_tready", {31'h0, s_trig_tready}, 1);

        // Basic frame and one-cycle latency
        exp_q.push_back(20'h5A123);
        send(16'h848C);
        send(16'h005A);
        stat_trig++;
        chk("t1_lat_valid", {31'h0, m_trig_tvalid}, 1);
        chk("t1_lat_data", {12'h0, m_trig_tdata}, 32'h5A123);
        @(posedge ifclk);
        #1 chk("t1_one_cycle", {31'h0, m_trig_tvalid}, 0);
        settle("t1_err");

        // Malformed address word
        send(16'h848D);
        err_exp++;
        stat_err++;
        settle("t2_err_bad");
        exp_q.push_back(20'h01123);
        send(16'h848C);
        send(16'h0001);
        stat_trig++;
        settle("t2_err");

        // Address word replaces a pending address
        send(16'h848C);
        send(16'h8000);
        err_exp++;
        stat_err++;
        exp_q.push_back(20'hFF000);
        send(16'h00FF);
        stat_trig++;
        settle("t3_err");

        // Timeout after 16 idle cycles
        send(16'h848C);
        repeat (15) @(posedge ifclk);
        #1 chk("t4_no_err_early", {31'h0, frame_err_o}, 0);
        @(posedge ifclk);
        #1 chk("t4_err_c17", {31'h0, frame_err_o}, 1);
        err_exp++;
        stat_err++;
        send(16'h005A);
        err_exp++;
        stat_err++;
        settle("t4_err");
        chk_stats("t4");

        // Backpressure with a full buffer
        m_trig_tready = 1'b0;
        exp_q.push_back(20'h11001);
        exp_q.push_back(20'h22002);
        exp_q.push_back(20'h33003);
        send(16'h8004);
        send(16'h0011);
        send(16'h8008);
        send(16'h0022);
        send(16'h800C);
        @(posedge ifclk);
        #1 chk("t5_stall_tready", {31'h0, s_trig_tready}, 0);
        chk("t5_head", {12'h0, m_trig_tdata}, 32'h11001);
        repeat (2) @(posedge ifclk);
        #1 m_trig_tready = 1'b1;
        send(16'h0033);
        stat_trig += 3;
        settle("t5_err");
        chk("t5_drained", exp_q.size(), 0);
        chk_stats("t5");

        // Clear wins over a same-cycle handshake
        send(16'h848C);
        s_trig_tdata  = 16'h0077;
        s_trig_tvalid = 1'b1;
        clear_i       = 1'b1;
        #1 chk("clr_tready", {31'h0, s_trig_tready}, 0);
        @(posedge ifclk);
        #1 clear_i = 1'b0;
        s_trig_tvalid = 1'b0;
        stat_trig = 0;
        stat_err  = 0;
        settle("clr_no_err");
        chk("clr_no_out", {31'h0, m_trig_tvalid}, 0);
        send(16'h0077);
        err_exp++;
        stat_err++;
        settle("clr_err");
        chk_stats("clr");

        // Reset mid-frame with a buffered trigger
        m_trig_tready = 1'b0;
        send(16'h848C);
        send(16'h0044);
        send(16'h8010);
        @(posedge ifclk);
        #1 chk("t6_buffered", {31'h0, m_trig_tvalid}, 1);
        ifclk_rstn = 1'b0;
        #1 chk("t6_async_clr", {31'h0, m_trig_tvalid}, 0);
        stat_trig = 0;
        stat_err  = 0;
        repeat (2) @(posedge ifclk);
        #1 ifclk_rstn = 1'b1;
        m_trig_tready = 1'b1;
        @(posedge ifclk);
        #1 chk("t6_tready", {31'h0, s_trig_tready}, 1);
        send(16'h005A);
        err_exp++;
        stat_err++;
        settle("t6_err");
        chk("t6_no_out", {31'h0, m_trig_tvalid}, 0);
        chk_stats("t6");
        chk("final_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
